// File: rtl/cyber_player.sv
// Computer opponent for tug-of-war: periodic decision ticks, LFSR versus difficulty,
// single-cycle press pulse for the playfield R input.
module cyber_player #(
    parameter int unsigned DIV_BITS = 24,
    parameter logic [9:0]  SEED     = 10'h001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       halt,
    input  logic [8:0] difficulty,
    output logic       press,
    output logic       tick,
    output logic [9:0] lfsr_q
);

    localparam int unsigned LFSR_W = 10;
    localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;
    localparam logic [DIV_BITS-1:0] CNT_MAX = '1;

    logic [DIV_BITS-1:0] cnt;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [LFSR_W-1:0]   lfsr_next;

    // x^10 + x^7 + 1 Fibonacci step; the all-zero lock-up state is never loaded
    always_comb begin
        lfsr_step = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        lfsr_next = (lfsr_step == '0) ? LFSR_W'(1) : lfsr_step;
    end

    // Halt freezes the divider even on the wrap edge, so the tick fires once halt drops
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            lfsr_q <= SEED_SAFE;
            tick   <= 1'b0;
            press  <= 1'b0;
        end else begin
            tick  <= 1'b0;
            press <= 1'b0;
            if (!enable) begin
                cnt <= '0;
            end else if (!halt) begin
                if (cnt == CNT_MAX) begin
                    cnt    <= '0;
                    tick   <= 1'b1;
                    press  <= {1'b0, difficulty} > lfsr_q;
                    lfsr_q <= lfsr_next;
                end else begin
                    cnt <= cnt + DIV_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cyber_player.sv
// Scoreboard bench for cyber_player (DIV_BITS=2): stimulus queues expected tick events,
// a negedge monitor pops and compares them whenever tick or press is seen.
module tb_cyber_player;

    typedef struct packed {
        int unsigned cyc;
        logic        press;
        logic [9:0]  lfsr;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       halt;
    logic [8:0] difficulty;
    logic       press;
    logic       tick;
    logic [9:0] lfsr_q;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];
    logic [9:0]  seq [0:20];

    cyber_player #(.DIV_BITS(2), .SEED(10'h001)) dut (
        .clk(clk), .reset(reset), .enable(enable), .halt(halt),
        .difficulty(difficulty), .press(press), .tick(tick), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_tick(input int unsigned at, input logic p, input logic [9:0] l);
        ev_t e;
        e.cyc = at; e.press = p; e.lfsr = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed tick/press must match the next queued expectation
    always @(negedge clk) begin
        if (tick || press) begin
            ev_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got tick=%0b press=%0b lfsr=%03h at cycle %0d, expected none",
                         tick, press, lfsr_q, cyc);
            end else begin
                e = exp_q.pop_front();
                if (!tick || press !== e.press || lfsr_q !== e.lfsr || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL tick_event: got tick=%0b press=%0b lfsr=%03h cycle=%0d, expected tick=1 press=%0b lfsr=%03h cycle=%0d",
                             tick, press, lfsr_q, cyc, e.press, e.lfsr, e.cyc);
                end
            end
        end
    end

    initial begin
        // Hand-derived x^10+x^7+1 sequence from seed 001
        seq = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
                10'h081, 10'h102, 10'h204, 10'h009, 10'h012, 10'h024, 10'h048,
                10'h091, 10'h122, 10'h244, 10'h088, 10'h110, 10'h220, 10'h041};

        reset = 1'b0; enable = 1'b1; halt = 1'b0; difficulty = 9'd511;
        repeat (2) @(negedge clk);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_press", 32'(press), 32'd0);
        check("reset_lfsr", 32'(lfsr_q), 32'h001);

        // First ticks after release: cycles 4, 8, 12, 16
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) expect_tick(cyc + 4 * i, 1'b1, seq[i]);
        repeat (16) @(negedge clk);

        // difficulty 0: ticks continue, press never
        difficulty = 9'd0;
        for (int i = 1; i <= 16; i++) expect_tick(cyc + 4 * i, 1'b0, seq[4 + i]);
        repeat (64) @(negedge clk);

        // difficulty 3 from seed: 3>1, 3>2, not 3>4
        reset = 1'b0; difficulty = 9'd3;
        repeat (2) @(negedge clk);
        check("reset2_lfsr", 32'(lfsr_q), 32'h001);
        check("reset2_tick", 32'(tick), 32'd0);
        reset = 1'b1;
        expect_tick(cyc + 4, 1'b1, 10'h002);
        expect_tick(cyc + 8, 1'b1, 10'h004);
        expect_tick(cyc + 12, 1'b0, 10'h008);
        repeat (12) @(negedge clk);

        // Halt at cnt=3 for 10 cycles; tick on the first edge after release
        repeat (3) @(negedge clk);
        halt = 1'b1; difficulty = 9'd15;
        repeat (10) @(negedge clk);
        check("halt_lfsr_frozen", 32'(lfsr_q), 32'h008);
        check("halt_tick", 32'(tick), 32'd0);
        halt = 1'b0;
        expect_tick(cyc + 1, 1'b1, 10'h010);
        repeat (1) @(negedge clk);

        // Disable mid-count for 5 cycles; full period after re-enable
        repeat (2) @(negedge clk);
        enable = 1'b0; difficulty = 9'd511;
        repeat (5) @(negedge clk);
        check("disable_lfsr_hold", 32'(lfsr_q), 32'h010);
        check("disable_press", 32'(press), 32'd0);
        enable = 1'b1;
        expect_tick(cyc + 4, 1'b1, 10'h020);
        repeat (4) @(negedge clk);

        // Reset on a wrap edge suppresses the tick and clears cnt
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (1) @(negedge clk);
        check("wrap_reset_tick", 32'(tick), 32'd0);
        check("wrap_reset_press", 32'(press), 32'd0);
        check("wrap_reset_lfsr", 32'(lfsr_q), 32'h001);
        reset = 1'b1;
        expect_tick(cyc + 4, 1'b1, 10'h002);
        repeat (7) @(negedge clk);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
